// File: rtl/mult4bit_controller_if.sv
// Handshake and datapath-strobe bundle between the shift-add multiplier controller
// and its datapath/host side.
interface mult4bit_controller_if #(
    parameter int N = 4
);
    logic             start;
    logic [N-1:0]     B;
    logic [2*N-1:0]   S;
    logic             init;
    logic             plus;
    logic             shift;
    logic             finish;
    logic             ready;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        input  start, B, S,
        output init, plus, shift, finish, ready, done, product
    );

    modport slave (
        output start, B, S,
        input  init, plus, shift, finish, ready, done, product
    );
endinterface

// File: rtl/mult4bit_controller.sv
// Sequencing FSM for the N-bit shift-add multiplier datapath; holds the final product.
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are zero.
module mult4bit_controller #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    mult4bit_controller_if.master     bus
);
    // state | meaning
    // IDLE  | ready=1, waiting for start
    // INIT  | init strobe, iteration counter cleared
    // RUN   | one plus or shift per cycle, driven by B[0]
    // FIN   | finish strobe, S is final and captured into product
    // DONE  | done pulse, product valid
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RUN  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  product_q;
    logic            last_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product_q <= '0;
        end else if (state == FIN) begin
            product_q <= bus.S;
        end
    end

    always_comb begin
        state_nxt  = state;
        bus.init   = 1'b0;
        bus.plus   = 1'b0;
        bus.shift  = 1'b0;
        bus.finish = 1'b0;
        bus.ready  = 1'b0;
        bus.done   = 1'b0;
        last_op    = (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_nxt = INIT;
            end
            INIT: begin
                bus.init  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
`ifdef MULT_EARLY_EXIT_EN
                // Once the upper multiplier bits are zero, this cycle's op is the last useful one.
                if (bus.B == '0) begin
                    last_op = 1'b1;
                end else begin
                    bus.plus  = bus.B[0];
                    bus.shift = ~bus.B[0];
                    if (bus.B[N-1:1] == '0) last_op = 1'b1;
                end
`else
                bus.plus  = bus.B[0];
                bus.shift = ~bus.B[0];
`endif
                if (last_op) state_nxt = FIN;
            end
            FIN: begin
                bus.finish = 1'b1;
                state_nxt  = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.product = product_q;

`ifndef MULT_EARLY_EXIT_EN
    logic unused_b_upper;
    assign unused_b_upper = ^bus.B[N-1:1];
`endif
endmodule
